// File: rtl/rts_cts_pkg.sv
// rtl/rts_cts_pkg.sv - shared state encoding, default thresholds/timers and counter width
package rts_cts_pkg;

    typedef enum logic [2:0] {
        FC_IDLE      = 3'd0,
        FC_WAIT_ROOM = 3'd1,
        FC_GRANT     = 3'd2,
        FC_DRAIN     = 3'd3,
        FC_BACKOFF   = 3'd4
    } fc_state_t;

    localparam int unsigned DEF_HI_THR  = 12;
    localparam int unsigned DEF_LO_THR  = 4;
    localparam int unsigned DEF_TIMEOUT = 1024;
    localparam int unsigned DEF_BACKOFF = 64;
    localparam int unsigned GRANT_CNT_W = 16;

    function automatic logic [GRANT_CNT_W-1:0] sat_inc(input logic [GRANT_CNT_W-1:0] v);
        return (&v) ? v : v + GRANT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rts_cts_flow_ctrl_if.sv
// rtl/rts_cts_flow_ctrl_if.sv - pin/FIFO-side signal bundle of the flow controller
interface rts_cts_flow_ctrl_if
    import rts_cts_pkg::*;
#(
    parameter int unsigned LEVEL_W = 8
) ();
    logic                   rts;
    logic                   enable;
    logic [LEVEL_W-1:0]     rx_level;
    logic                   rx_strobe;
    logic                   cts;
    logic                   timeout_pulse;
    logic [2:0]             fc_state;
    logic [GRANT_CNT_W-1:0] grant_cnt;

    modport master (
        output rts, enable, rx_level, rx_strobe,
        input  cts, timeout_pulse, fc_state, grant_cnt
    );

    modport slave (
        input  rts, enable, rx_level, rx_strobe,
        output cts, timeout_pulse, fc_state, grant_cnt
    );
endinterface

// File: rtl/rts_sync_filter.sv
// rtl/rts_sync_filter.sv - rts metastability synchroniser followed by a stability filter
module rts_sync_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rts,
    output logic rts_f
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rts_s;

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("rts_sync_filter: SYNC_STAGES must be >= 2");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rts};
        end
    end

    assign rts_s = sync_q[SYNC_STAGES-1];

    if (FILT_LEN == 0) begin : g_bypass
        assign rts_f = rts_s;
    end else begin : g_filt
        localparam int unsigned CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
        logic [CW-1:0] cnt_q, cnt_d;
        logic          f_q, f_d;

        // Any cycle where rts_s agrees with the filtered value restarts the run.
        always_comb begin
            cnt_d = '0;
            f_d   = f_q;
            if (rts_s != f_q) begin
                if (cnt_q == CW'(FILT_LEN - 1)) begin
                    f_d = rts_s;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
                f_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                f_q   <= f_d;
            end
        end

        assign rts_f = f_q;
    end
endmodule

// File: rtl/rts_cts_flow_ctrl.sv
// rtl/rts_cts_flow_ctrl.sv - RTS/CTS grant FSM with level hysteresis, no-data timeout and backoff
module rts_cts_flow_ctrl
    import rts_cts_pkg::*;
#(
    parameter int unsigned LEVEL_W     = 8,
    parameter int unsigned HI_THR      = DEF_HI_THR,
    parameter int unsigned LO_THR      = DEF_LO_THR,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned BACKOFF     = DEF_BACKOFF
) (
    input  logic                clk,
    input  logic                rst,
    rts_cts_flow_ctrl_if.slave  fc
);
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = $clog2(BACKOFF + 1);
    localparam logic [LEVEL_W-1:0] HI_L = LEVEL_W'(HI_THR);
    localparam logic [LEVEL_W-1:0] LO_L = LEVEL_W'(LO_THR);

    if (LO_THR >= HI_THR) begin : g_chk_thr
        $error("rts_cts_flow_ctrl: LO_THR must be below HI_THR");
    end
    if (TIMEOUT < 1 || BACKOFF < 1) begin : g_chk_tmr
        $error("rts_cts_flow_ctrl: TIMEOUT and BACKOFF must be >= 1");
    end

    fc_state_t              state_q, state_d;
    logic [IW-1:0]          idle_cnt_q, idle_cnt_d;
    logic [BW-1:0]          bo_cnt_q, bo_cnt_d;
    logic                   cts_q, cts_d;
    logic                   tp_q, tp_d;
    logic [GRANT_CNT_W-1:0] gcnt_q, gcnt_d;
    logic                   rts_f;
    logic                   lvl_hi, lvl_lo, idle_expired, bo_done, grant_entry;

    rts_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_filter (
        .clk   (clk),
        .rst   (rst),
        .rts   (fc.rts),
        .rts_f (rts_f)
    );

    assign lvl_hi       = fc.rx_level >= HI_L;
    assign lvl_lo       = fc.rx_level <= LO_L;
    assign idle_expired = idle_cnt_q == IW'(TIMEOUT - 1);
    assign bo_done      = bo_cnt_q == BW'(BACKOFF - 1);

    // Throttle outranks release, which outranks timeout; a strobe on the expiry cycle keeps the grant.
    always_comb begin
        state_d = state_q;
        if (!fc.enable) begin
            state_d = FC_IDLE;
        end else begin
            case (state_q)
                FC_IDLE: begin
                    if (rts_f) state_d = lvl_lo ? FC_GRANT : FC_WAIT_ROOM;
                end
                FC_WAIT_ROOM: begin
                    if (!rts_f)      state_d = FC_IDLE;
                    else if (lvl_lo) state_d = FC_GRANT;
                end
                FC_GRANT: begin
                    if (lvl_hi)                              state_d = FC_DRAIN;
                    else if (!rts_f)                         state_d = FC_IDLE;
                    else if (idle_expired && !fc.rx_strobe)  state_d = FC_BACKOFF;
                end
                FC_DRAIN: begin
                    if (lvl_lo) state_d = rts_f ? FC_GRANT : FC_IDLE;
                end
                FC_BACKOFF: begin
                    if (bo_done) state_d = FC_IDLE;
                end
                default: state_d = FC_IDLE;
            endcase
        end
    end

    always_comb begin
        grant_entry = (state_d == FC_GRANT) && (state_q != FC_GRANT);
        idle_cnt_d  = idle_cnt_q;
        if (grant_entry || fc.rx_strobe) begin
            idle_cnt_d = '0;
        end else if (state_q == FC_GRANT) begin
            idle_cnt_d = idle_cnt_q + IW'(1);
        end
        bo_cnt_d = (state_q == FC_BACKOFF) ? bo_cnt_q + BW'(1) : '0;
        cts_d    = state_d == FC_GRANT;
        tp_d     = (state_q == FC_GRANT) && (state_d == FC_BACKOFF);
        gcnt_d   = grant_entry ? sat_inc(gcnt_q) : gcnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FC_IDLE;
            idle_cnt_q <= '0;
            bo_cnt_q   <= '0;
            cts_q      <= 1'b0;
            tp_q       <= 1'b0;
            gcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            bo_cnt_q   <= bo_cnt_d;
            cts_q      <= cts_d;
            tp_q       <= tp_d;
            gcnt_q     <= gcnt_d;
        end
    end

    assign fc.cts           = cts_q;
    assign fc.timeout_pulse = tp_q;
    assign fc.fc_state      = state_q;
    assign fc.grant_cnt     = gcnt_q;
endmodule

// File: tb/tb_rts_cts_flow_ctrl.sv
// tb/tb_rts_cts_flow_ctrl.sv - randomized and directed scoreboard bench for rts_cts_flow_ctrl
module tb_rts_cts_flow_ctrl;
    localparam int SYNC = 2, FILT = 4, HI = 12, LO = 4, TMO = 1024, BOF = 64;
    localparam int S_IDLE = 0, S_WAIT = 1, S_GRANT = 2, S_DRAIN = 3, S_BACK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rts_cts_flow_ctrl_if #(.LEVEL_W(8)) fc_if ();

    rts_cts_flow_ctrl #(
        .LEVEL_W(8), .HI_THR(HI), .LO_THR(LO), .SYNC_STAGES(SYNC),
        .FILT_LEN(FILT), .TIMEOUT(TMO), .BACKOFF(BOF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fc  (fc_if)
    );

    logic [20:0] exp_q[$];

    function automatic logic [20:0] pack(input int c, input int tp, input int st, input int gc);
        return {c[0], tp[0], st[2:0], gc[15:0]};
    endfunction

    // Reference model: rts history queue, mismatch run length, and "edges since last activity".
    initial begin
        int hist[$];
        int mf, run, mst, bo_left, gcnt, rs, pre_f, nxt, old, tp;
        longint edge_no, last_act;
        mf = 0; run = 0; mst = S_IDLE; bo_left = 0; gcnt = 0; edge_no = 0; last_act = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                hist = {};
                mf = 0; run = 0; mst = S_IDLE; bo_left = 0; gcnt = 0; edge_no = 0; last_act = 0;
                exp_q.push_back(pack(0, 0, S_IDLE, 0));
            end else begin
                edge_no++;
                rs = (hist.size() >= SYNC) ? hist[SYNC-1] : 0;
                hist.push_front(int'(fc_if.rts));
                if (hist.size() > SYNC + 1) void'(hist.pop_back());
                pre_f = mf;
                if (rs != mf) begin
                    run++;
                    if (run == FILT) begin
                        mf = rs;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
                old = mst;
                nxt = old;
                if (!fc_if.enable) begin
                    nxt = S_IDLE;
                end else if (old == S_IDLE) begin
                    if (pre_f != 0) nxt = (fc_if.rx_level <= LO) ? S_GRANT : S_WAIT;
                end else if (old == S_WAIT) begin
                    if (pre_f == 0) nxt = S_IDLE;
                    else if (fc_if.rx_level <= LO) nxt = S_GRANT;
                end else if (old == S_GRANT) begin
                    if (fc_if.rx_level >= HI) nxt = S_DRAIN;
                    else if (pre_f == 0) nxt = S_IDLE;
                    else if (edge_no - last_act == TMO && !fc_if.rx_strobe) nxt = S_BACK;
                end else if (old == S_DRAIN) begin
                    if (fc_if.rx_level <= LO) nxt = (pre_f != 0) ? S_GRANT : S_IDLE;
                end else begin
                    bo_left--;
                    if (bo_left == 0) nxt = S_IDLE;
                end
                if (nxt == S_GRANT && old != S_GRANT) begin
                    last_act = edge_no;
                    if (gcnt < 65535) gcnt++;
                end
                if (fc_if.rx_strobe) last_act = edge_no;
                if (nxt == S_BACK && old != S_BACK) bo_left = BOF;
                tp = (old == S_GRANT && nxt == S_BACK) ? 1 : 0;
                mst = nxt;
                exp_q.push_back(pack((mst == S_GRANT) ? 1 : 0, tp, mst, gcnt));
            end
        end
    end

    // Monitor: the DUT presents its registered outputs every cycle.
    initial begin
        logic [20:0] e, g;
        forever begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty at %0t: no expected entry", $time);
            end else begin
                e = exp_q.pop_front();
                g = {fc_if.cts, fc_if.timeout_pulse, fc_if.fc_state, fc_if.grant_cnt};
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard at %0t: got cts=%0b tp=%0b st=%0d gc=%0d, want cts=%0b tp=%0b st=%0d gc=%0d",
                             $time, g[20], g[19], g[18:16], g[15:0], e[20], e[19], e[18:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, seen, lv;
        fc_if.rts = 1'b0; fc_if.enable = 1'b1; fc_if.rx_level = '0; fc_if.rx_strobe = 1'b0;
        repeat (3) tick();
        chk("reset_cts", int'(fc_if.cts), 0);
        chk("reset_state", int'(fc_if.fc_state), S_IDLE);
        rst = 1'b0;
        repeat (2) tick();

        // 3-cycle glitch must not pass the filter
        fc_if.rts = 1'b1;
        repeat (3) tick();
        fc_if.rts = 1'b0;
        seen = 0;
        repeat (12) begin
            tick();
            if (fc_if.cts) seen = 1;
        end
        chk("glitch_cts", seen, 0);
        chk("glitch_grant_cnt", int'(fc_if.grant_cnt), 0);

        fc_if.rts = 1'b1;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (fc_if.cts) break;
        end
        chk("rise_latency", k, 7);
        chk("rise_grant_cnt", int'(fc_if.grant_cnt), 1);

        fc_if.rx_level = 8'd11;
        tick();
        chk("lvl11_state", int'(fc_if.fc_state), S_GRANT);
        fc_if.rx_level = 8'd12;
        tick();
        chk("lvl12_cts", int'(fc_if.cts), 0);
        chk("lvl12_state", int'(fc_if.fc_state), S_DRAIN);
        fc_if.rx_level = 8'd5;
        repeat (3) tick();
        chk("lvl5_cts", int'(fc_if.cts), 0);
        fc_if.rx_level = 8'd4;
        tick();
        chk("lvl4_cts", int'(fc_if.cts), 1);
        chk("lvl4_grant_cnt", int'(fc_if.grant_cnt), 2);

        fc_if.rx_level = 8'd0;
        for (k = 1; k <= 1100; k++) begin
            tick();
            if (fc_if.timeout_pulse) break;
        end
        chk("timeout_cycles", k, 1024);
        chk("timeout_cts", int'(fc_if.cts), 0);
        chk("timeout_state", int'(fc_if.fc_state), S_BACK);
        tick();
        chk("timeout_pulse_width", int'(fc_if.timeout_pulse), 0);
        for (k = 2; k <= 200; k++) begin
            if (fc_if.fc_state == 3'(S_IDLE)) break;
            tick();
        end
        chk("backoff_cycles", k, 65);
        tick();
        chk("regrant_cts", int'(fc_if.cts), 1);
        chk("regrant_cnt", int'(fc_if.grant_cnt), 3);

        repeat (1023) tick();
        fc_if.rx_level = 8'd12;
        tick();
        chk("coincide_state", int'(fc_if.fc_state), S_DRAIN);
        chk("coincide_pulse", int'(fc_if.timeout_pulse), 0);
        fc_if.rx_level = 8'd0;
        tick();
        chk("coincide_regrant", int'(fc_if.cts), 1);
        for (k = 1; k <= 1100; k++) begin
            tick();
            if (fc_if.timeout_pulse) break;
        end
        chk("timeout2_cycles", k, 1024);
        repeat (3) tick();
        fc_if.enable = 1'b0;
        tick();
        chk("disable_backoff_state", int'(fc_if.fc_state), S_IDLE);
        chk("disable_backoff_cts", int'(fc_if.cts), 0);
        fc_if.enable = 1'b1;
        tick();
        chk("reenable_cts", int'(fc_if.cts), 1);
        chk("reenable_grant_cnt", int'(fc_if.grant_cnt), 5);

        // Asynchronous reset in GRANT, sampled between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cts", int'(fc_if.cts), 0);
        chk("async_rst_grant_cnt", int'(fc_if.grant_cnt), 0);
        chk("async_rst_state", int'(fc_if.fc_state), S_IDLE);
        tick();
        rst = 1'b0;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (fc_if.cts) break;
        end
        chk("post_rst_latency", k, 7);

        lv = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) fc_if.rts = ~fc_if.rts;
            if ($urandom_range(0, 29) == 0) lv = int'($urandom_range(0, 20));
            else if ($urandom_range(0, 2) == 0) lv = lv + int'($urandom_range(0, 4)) - 2;
            if (lv < 0) lv = 0;
            if (lv > 20) lv = 20;
            fc_if.rx_level = 8'(lv);
            fc_if.rx_strobe = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) fc_if.enable = ~fc_if.enable;
            tick();
        end
        fc_if.enable = 1'b1;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
